hyperbus_w_packer: RTL and testbench
====================================

Name: hyperbus_w_packer

Overview:
Write-path counterpart of the HyperBus read splitter. Takes AXI W beats (data and strobes; narrow or wide, aligned or unaligned) and repacks them into PHY-width words of 16*NumPhys bits, each with a per-byte enable and a last flag. It sits between the AXI slave W channel and the PHY-side TX CDC FIFO. Narrow beats that share one PHY word are merged into a single PHY word before it is sent.

Parameters:
AxiDataWidth, 64, AXI data width in bits; power of two; AxiBytes = AxiDataWidth/8 must be >= PhyBytes.
NumPhys, 2, number of PHYs; PhyBytes = 2*NumPhys bytes per PHY word.
BurstLenWidth, 8, width of burst_len (AXI len: beats minus 1).
CntWidth, 16, width of the internal byte-address counter; wraps modulo 2^CntWidth.
AddrWidth, $clog2(AxiBytes), width of start_addr (byte offset within an AXI word).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
trans_handshake  in  1  AW accepted this cycle
is_a_write  in  1  qualifies trans_handshake
start_addr  in  AddrWidth  AW address low bits
size  in  3  AW size (log2 bytes per beat), <= log2(AxiBytes)
burst_len  in  BurstLenWidth  AW len
axi_valid_i  in  1  W valid
axi_ready_o  out  1  W ready
axi_data_i  in  AxiDataWidth  W data
axi_strb_i  in  AxiBytes  W strobe
axi_last_i  in  1  W last
phy_valid_o  out  1  PHY word valid
phy_ready_i  in  1  PHY word ready
phy_data_o  out  16*NumPhys  PHY word data
phy_strb_o  out  2*NumPhys  byte enable, active-high (PHY inverts to produce RWDS mask)
phy_last_o  out  1  final PHY word of the burst
err_o  out  1  W last mismatch (see Optional Feature)

Behaviour:
- Reset: state Idle. axi_ready_o=0, phy_valid_o=0, phy_data_o=0, phy_strb_o=0, phy_last_o=0, err_o=0. All counters and buffers cleared.
- Reset asserted mid-burst aborts the burst immediately. No partial word is emitted.
- Registers:
  - byte_addr (CntWidth), loaded with start_addr.
  - size_q.
  - beat_cnt, loaded with burst_len.
  - beat buffer: data, strb, last flag.
  - word accumulator: acc_data, acc_strb, PhyBytes wide.
- States:
  - Idle: on trans_handshake & is_a_write, load the registers, clear the accumulator, go to Load. trans_handshake outside Idle is ignored.
  - Load: axi_ready_o=1, phy_valid_o=0. On axi_valid_i, store the beat and go to Send. Latency from W handshake to first phy_valid_o is 1 cycle.
  - Send: axi_ready_o=0. Walks the PHY words of the current beat window.
- Beat window: bytes byte_addr up to aligned(byte_addr,size_q)+2^size_q-1.
- Word pointer wp = (byte_addr mod AxiBytes)/PhyBytes.
- Lane rule for each word: lane i is enabled if its byte lies in the window and the matching axi_strb bit is set.
  - acc_data lane i takes beat byte wp*PhyBytes+i when enabled, otherwise keeps its old value.
  - acc_strb |= enabled lanes.
- Word complete when either:
  - the window reaches the word's upper boundary, or
  - this is the final word of the final beat (beat_cnt==0).
- Complete word:
  - Drive phy_valid_o=1 with phy_data_o=acc_data, phy_strb_o=acc_strb.
  - phy_last_o=1 only on the final word of the final beat.
  - Outputs hold stable while phy_ready_i=0.
  - On handshake: clear the accumulator and advance byte_addr to the next PHY word boundary, capped at the window end.
- Incomplete word (narrow beat inside a word): merge into the accumulator with no PHY output. Set byte_addr = aligned(byte_addr,size_q)+2^size_q and go to Load.
- When the window is exhausted:
  - beat_cnt==0: go to Idle.
  - otherwise: decrement beat_cnt and go to Load.
- A PHY word whose lanes are all disabled is still sent (strb=0) if it lies in the window. Address continuity at the PHY is preserved.
- byte_addr wraps modulo 2^CntWidth. Only its low AddrWidth bits select lanes.
- Without the macro, axi_last_i is ignored. The burst end is set by beat_cnt alone.

Optional Feature:
Macro HYPERBUS_W_LAST_CHECK_EN.
- Defined:
  - err_o is set when a W beat is accepted with axi_last_i != (beat_cnt==0).
  - err_o is sticky until the next accepted write trans_handshake, which clears it.
  - Data flow is unaffected.
- Not defined: err_o is tied to 0 and no check logic is built.

Test Plan:
All tests use AxiDataWidth=64, NumPhys=2 (PhyBytes=4).
1. Wide aligned burst: start_addr=0x0, size=3, len=1; beats 0x1122334455667788, 0x99AABBCCDDEEFF00, strb=0xFF -> 4 PHY words: 0x55667788, 0x11223344, 0xDDEEFF00, 0x99AABBCC. strb=0xF on each; phy_last_o only on the 4th word.
2. Narrow merge: start_addr=0x0, size=1, len=3; beats carry 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD in the matching lanes, strb full -> exactly 2 PHY words: 0xBBBBAAAA, 0xDDDDCCCC. strb=0xF each; last on the 2nd word.
3. Unaligned single beat: start_addr=0x6, size=3, len=0, strb=0xC0, data 0xDEAD... in the upper bytes -> 1 PHY word: data bits 63:32, strb=0xC, phy_last_o=1. Returns to Idle.
4. Backpressure: in test 1, hold phy_ready_i=0 for 3 cycles on word 2 -> phy_data_o, phy_strb_o and phy_last_o stay constant; axi_ready_o=0 throughout; all 4 words are still delivered in order.
5. Reset mid-burst: assert rst_ni=0 during word 2 of test 1 -> next cycle phy_valid_o=0, axi_ready_o=0. A fresh test 3 transaction then completes correctly.
6. With HYPERBUS_W_LAST_CHECK_EN: len=1 with axi_last_i=1 on beat 0 -> err_o=1 from the next cycle, held through the burst, cleared by the next write trans_handshake. Without the macro, err_o stays 0.

Source files
------------

// File: rtl/hyperbus_w_packer.sv
// -----------------------------------------------------------------------------
// hyperbus_w_packer
//
// Write-path packer between the AXI slave W channel and the PHY-side TX CDC
// FIFO. Repacks AXI W beats (narrow or wide, aligned or unaligned) into PHY
// words of 16*NumPhys bits with an active-high per-byte enable and a last
// flag. Narrow beats that share one PHY word are merged before it is sent.
//
// Optional feature (compile-time macro HYPERBUS_W_LAST_CHECK_EN):
//   defined     -> err_o flags a W beat whose axi_last_i disagrees with the
//                  burst length; sticky until the next accepted write AW.
//   not defined -> err_o is tied low and axi_last_i is ignored.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   trans_handshake        AW accepted this cycle (qualified by is_a_write)
//   start_addr/size/len    AW byte offset in the AXI word, log2 beat bytes, len
//   axi_valid_i/ready_o    W handshake; axi_data_i/strb_i/last_i W payload
//   phy_valid_o/ready_i    PHY word handshake
//   phy_data_o/strb_o      PHY word and byte enables; phy_last_o final word
//   err_o                  W last mismatch (see macro above)
// -----------------------------------------------------------------------------
module hyperbus_w_packer #(
  parameter int unsigned AxiDataWidth  = 64,
  parameter int unsigned NumPhys       = 2,
  parameter int unsigned BurstLenWidth = 8,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned AddrWidth     = $clog2(AxiDataWidth / 8)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      trans_handshake,
  input  logic                      is_a_write,
  input  logic [AddrWidth-1:0]      start_addr,
  input  logic [2:0]                size,
  input  logic [BurstLenWidth-1:0]  burst_len,
  input  logic                      axi_valid_i,
  output logic                      axi_ready_o,
  input  logic [AxiDataWidth-1:0]   axi_data_i,
  input  logic [AxiDataWidth/8-1:0] axi_strb_i,
  input  logic                      axi_last_i,
  output logic                      phy_valid_o,
  input  logic                      phy_ready_i,
  output logic [16*NumPhys-1:0]     phy_data_o,
  output logic [2*NumPhys-1:0]      phy_strb_o,
  output logic                      phy_last_o,
  output logic                      err_o
);

  localparam int unsigned AxiBytes = AxiDataWidth / 8;
  localparam int unsigned PhyBytes = 2 * NumPhys;
  localparam int unsigned PhyWidth = 16 * NumPhys;
  localparam int unsigned PhyAddrW = $clog2(PhyBytes);

  typedef enum logic [1:0] {Idle, Load, Send} state_e;

  state_e                   state_q, state_d;
  logic [CntWidth-1:0]      byte_addr_q;
  logic [2:0]               size_q;
  logic [BurstLenWidth-1:0] beat_cnt_q;
  logic [AxiDataWidth-1:0]  beat_data_q;
  logic [AxiBytes-1:0]      beat_strb_q;
  logic [PhyWidth-1:0]      acc_data_q;
  logic [PhyBytes-1:0]      acc_strb_q;

  logic                     aw_write;
  logic [CntWidth-1:0]      size_mask, win_rem, word_rem, step;
  logic [PhyAddrW-1:0]      lane_off;
  logic [AddrWidth-1:0]     lane_base;
  logic [PhyBytes-1:0]      lane_en, merged_strb;
  logic [PhyWidth-1:0]      merged_data;
  logic                     final_beat, win_done, word_done, is_last, send_word;

  assign aw_write = trans_handshake && is_a_write;

  // Window / word decode for the current byte_addr. win_rem is the number of
  // bytes left in the beat window, word_rem the bytes left up to the next PHY
  // word boundary; comparing the two decides completion and window exhaustion.
  always_comb begin
    // NOTE: every variable driven here gets a value before any branch or loop,
    // so no latch can be inferred.
    lane_en     = '0;
    merged_data = '0;
    size_mask   = (CntWidth'(1) << size_q) - CntWidth'(1);
    win_rem     = size_mask - (byte_addr_q & size_mask) + CntWidth'(1);
    lane_off    = byte_addr_q[PhyAddrW-1:0];
    word_rem    = CntWidth'(PhyBytes) - CntWidth'(lane_off);
    // Only the low AddrWidth bits of the wrapping counter select AXI lanes.
    lane_base   = byte_addr_q[AddrWidth-1:0] & ~AddrWidth'(PhyBytes - 1);
    final_beat  = (beat_cnt_q == '0);
    win_done    = (win_rem <= word_rem);
    word_done   = (win_rem >= word_rem) || final_beat;
    is_last     = final_beat && win_done;
    step        = win_done ? win_rem : word_rem;
    for (int i = 0; i < int'(PhyBytes); i++) begin
      lane_en[i] = (i >= int'(lane_off)) && ((i - int'(lane_off)) < int'(win_rem))
                   && beat_strb_q[int'(lane_base) + i];
      merged_data[i*8 +: 8] = lane_en[i] ? beat_data_q[(int'(lane_base) + i)*8 +: 8]
                                         : acc_data_q[i*8 +: 8];
    end
    merged_strb = acc_strb_q | lane_en;
  end

  assign send_word = (state_q == Send) && word_done;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: clocked state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  // Next-state logic. AW handshakes outside Idle are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle: if (aw_write) state_d = Load;
      Load: if (axi_valid_i) state_d = Send;
      Send: begin
        // Leave Send once the window is used up: either a partial word was
        // merged (never the final beat) or the last word of the window went out.
        if (!word_done || (phy_ready_i && win_done)) state_d = final_beat ? Idle : Load;
      end
      default: state_d = Idle;
    endcase
  end

  // Outputs. Everything is derived from registers, so a stalled word holds.
  always_comb begin
    axi_ready_o = (state_q == Load);
    phy_valid_o = send_word;
    phy_data_o  = send_word ? merged_data : '0;
    phy_strb_o  = send_word ? merged_strb : '0;
    phy_last_o  = send_word && is_last;
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the beat buffer and accumulator are reset as well, so a burst
      // aborted by reset can never leak stale bytes into the next one.
      byte_addr_q <= '0;
      size_q      <= '0;
      beat_cnt_q  <= '0;
      beat_data_q <= '0;
      beat_strb_q <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
    end else begin
      unique case (state_q)
        Idle: if (aw_write) begin
          byte_addr_q <= CntWidth'(start_addr);
          size_q      <= size;
          beat_cnt_q  <= burst_len;
          acc_data_q  <= '0;
          acc_strb_q  <= '0;
        end
        Load: if (axi_valid_i) begin
          beat_data_q <= axi_data_i;
          beat_strb_q <= axi_strb_i;
        end
        Send: begin
          if (!word_done) begin
            // Narrow beat inside a word: merge and fetch the next beat.
            acc_data_q  <= merged_data;
            acc_strb_q  <= merged_strb;
            byte_addr_q <= byte_addr_q + win_rem;
            beat_cnt_q  <= beat_cnt_q - BurstLenWidth'(1);
          end else if (phy_ready_i) begin
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            byte_addr_q <= byte_addr_q + step;
            if (win_done && !final_beat) beat_cnt_q <= beat_cnt_q - BurstLenWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HYPERBUS_W_LAST_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (state_q == Idle && aw_write) begin
      err_q <= 1'b0;
    end else if (state_q == Load && axi_valid_i && (axi_last_i != final_beat)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_last;
  assign unused_last = axi_last_i;
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_hyperbus_w_packer.sv
// -----------------------------------------------------------------------------
// tb_hyperbus_w_packer
//
// Directed and randomized bench for hyperbus_w_packer (AxiDataWidth=64,
// NumPhys=2). Expected PHY words come from a byte-address reference model:
// every byte of every beat window is mapped to its absolute PHY word, and
// consecutive bytes in the same word are merged into one expected word.
// -----------------------------------------------------------------------------
module tb_hyperbus_w_packer;

  localparam int AxiDataWidth  = 64;
  localparam int NumPhys       = 2;
  localparam int BurstLenWidth = 8;
  localparam int CntWidth      = 16;
  localparam int AddrWidth     = 3;
  localparam int MaxCyc        = 2000;
`ifdef HYPERBUS_W_LAST_CHECK_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } word_t;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     trans_handshake, is_a_write;
  logic [AddrWidth-1:0]     start_addr;
  logic [2:0]               size;
  logic [BurstLenWidth-1:0] burst_len;
  logic                     axi_valid_i, axi_ready_o;
  logic [63:0]              axi_data_i;
  logic [7:0]               axi_strb_i;
  logic                     axi_last_i;
  logic                     phy_valid_o, phy_ready_i;
  logic [31:0]              phy_data_o;
  logic [3:0]               phy_strb_o;
  logic                     phy_last_o, err_o;

  word_t       exp_q[$];
  word_t       got_q[$];
  logic [63:0] beat_data [16];
  logic [7:0]  beat_strb [16];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk_i = ~clk_i;

  hyperbus_w_packer #(
    .AxiDataWidth (AxiDataWidth),
    .NumPhys      (NumPhys),
    .BurstLenWidth(BurstLenWidth),
    .CntWidth     (CntWidth),
    .AddrWidth    (AddrWidth)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .trans_handshake(trans_handshake),
    .is_a_write     (is_a_write),
    .start_addr     (start_addr),
    .size           (size),
    .burst_len      (burst_len),
    .axi_valid_i    (axi_valid_i),
    .axi_ready_o    (axi_ready_o),
    .axi_data_i     (axi_data_i),
    .axi_strb_i     (axi_strb_i),
    .axi_last_i     (axi_last_i),
    .phy_valid_o    (phy_valid_o),
    .phy_ready_i    (phy_ready_i),
    .phy_data_o     (phy_data_o),
    .phy_strb_o     (phy_strb_o),
    .phy_last_o     (phy_last_o),
    .err_o          (err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk every byte address of each INCR beat window.
  function automatic void build_model(input int start, input int sz, input int len);
    int    nb    = 1 << sz;
    int    base0 = (start / nb) * nb;
    int    cur_w = -1;
    word_t cur   = '0;
    exp_q.delete();
    for (int b = 0; b <= len; b++) begin
      int lo = (b == 0) ? start : base0 + b * nb;
      for (int a = lo; a < base0 + (b + 1) * nb; a++) begin
        if (a / 4 != cur_w) begin
          if (cur_w >= 0) exp_q.push_back(cur);
          cur   = '0;
          cur_w = a / 4;
        end
        if (beat_strb[b][a % 8]) begin
          cur.data[(a % 4)*8 +: 8] = beat_data[b][(a % 8)*8 +: 8];
          cur.strb[a % 4]          = 1'b1;
        end
      end
    end
    cur.last = 1'b1;
    exp_q.push_back(cur);
  endfunction

  task automatic run_burst(input string name, input int start, input int sz, input int len,
                           input bit rnd, input int stall_word, input int stall_len,
                           input int bad_last, input int abort_word);
    int    beat    = 0;
    int    cyc     = 0;
    int    stalls  = 0;
    bit    held    = 1'b0;
    bit    aborted = 1'b0;
    word_t hold_w  = '0;
    build_model(start, sz, len);
    got_q.delete();
    @(negedge clk_i);
    trans_handshake = 1'b1;
    is_a_write      = 1'b1;
    start_addr      = 3'(start);
    size            = 3'(sz);
    burst_len       = 8'(len);
    @(negedge clk_i);
    trans_handshake = 1'b0;
    while (!aborted && (beat <= len || got_q.size() < exp_q.size()) && cyc < MaxCyc) begin
      if (held) begin
        check({name, " hold valid"}, 64'(phy_valid_o), 64'd1);
        check({name, " hold word"}, 64'({phy_data_o, phy_strb_o, phy_last_o}), 64'(hold_w));
      end
      if (phy_valid_o) check({name, " axi_ready low while sending"}, 64'(axi_ready_o), 64'd0);
      if (abort_word == got_q.size() && phy_valid_o) begin
        rst_ni = 1'b0;
        #1;
        check({name, " reset phy_valid"}, 64'(phy_valid_o), 64'd0);
        check({name, " reset axi_ready"}, 64'(axi_ready_o), 64'd0);
        check({name, " reset phy_strb"}, 64'(phy_strb_o), 64'd0);
        aborted = 1'b1;
      end else begin
        axi_valid_i = (beat <= len) && (!rnd || $urandom_range(0, 3) != 0);
        axi_data_i  = beat_data[beat & 15];
        axi_strb_i  = beat_strb[beat & 15];
        axi_last_i  = (beat == len) ^ (beat == bad_last);
        if (rnd) begin
          // Stray AW handshakes mid-burst must be ignored.
          trans_handshake = ($urandom_range(0, 7) == 0);
          start_addr      = 3'($urandom);
        end
        if (stall_word == got_q.size() && phy_valid_o && stalls < stall_len) begin
          phy_ready_i = 1'b0;
          stalls++;
        end else begin
          phy_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        held   = phy_valid_o && !phy_ready_i;
        hold_w = {phy_data_o, phy_strb_o, phy_last_o};
        if (axi_ready_o && axi_valid_i) beat++;
        if (phy_valid_o && phy_ready_i) got_q.push_back(hold_w);
        @(negedge clk_i);
        cyc++;
      end
    end
    trans_handshake = 1'b0;
    axi_valid_i     = 1'b0;
    phy_ready_i     = 1'b1;
    if (aborted) begin
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
    end else begin
      check({name, " within cycle budget"}, 64'(cyc < MaxCyc), 64'd1);
      check({name, " word count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
        check($sformatf("%s word%0d data", name, k), 64'(got_q[k].data), 64'(exp_q[k].data));
        check($sformatf("%s word%0d strb", name, k), 64'(got_q[k].strb), 64'(exp_q[k].strb));
        check($sformatf("%s word%0d last", name, k), 64'(got_q[k].last), 64'(exp_q[k].last));
      end
      check({name, " idle axi_ready"}, 64'(axi_ready_o), 64'd0);
      check({name, " idle phy_valid"}, 64'(phy_valid_o), 64'd0);
    end
  endtask

  // Literal expectations taken straight from the directed scenarios.
  task automatic check_lit(input string name, input int k, input logic [31:0] d,
                           input logic [3:0] s, input logic l);
    if (k < got_q.size()) begin
      check($sformatf("%s lit%0d data", name, k), 64'(got_q[k].data), 64'(d));
      check($sformatf("%s lit%0d strb", name, k), 64'(got_q[k].strb), 64'(s));
      check($sformatf("%s lit%0d last", name, k), 64'(got_q[k].last), 64'(l));
    end
  endtask

  task automatic load_wide;
    beat_data[0] = 64'h1122334455667788;
    beat_data[1] = 64'h99AABBCCDDEEFF00;
    beat_strb[0] = 8'hFF;
    beat_strb[1] = 8'hFF;
  endtask

  task automatic load_unaligned;
    beat_data[0] = 64'hDEAD_0000_1234_5678;
    beat_strb[0] = 8'hC0;
  endtask

  task automatic check_wide(input string name);
    check({name, " lit count"}, 64'(got_q.size()), 64'd4);
    check_lit(name, 0, 32'h55667788, 4'hF, 1'b0);
    check_lit(name, 1, 32'h11223344, 4'hF, 1'b0);
    check_lit(name, 2, 32'hDDEEFF00, 4'hF, 1'b0);
    check_lit(name, 3, 32'h99AABBCC, 4'hF, 1'b1);
  endtask

  task automatic check_unaligned(input string name);
    check({name, " lit count"}, 64'(got_q.size()), 64'd1);
    check_lit(name, 0, 32'hDEAD0000, 4'hC, 1'b1);
  endtask

  initial begin
    rst_ni          = 1'b0;
    trans_handshake = 1'b0;
    is_a_write      = 1'b0;
    start_addr      = '0;
    size            = '0;
    burst_len       = '0;
    axi_valid_i     = 1'b0;
    axi_data_i      = '0;
    axi_strb_i      = '0;
    axi_last_i      = 1'b0;
    phy_ready_i     = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat_data[i] = '0;
      beat_strb[i] = '0;
    end
    repeat (3) @(negedge clk_i);
    check("reset axi_ready", 64'(axi_ready_o), 64'd0);
    check("reset phy_valid", 64'(phy_valid_o), 64'd0);
    check("reset phy_data", 64'(phy_data_o), 64'd0);
    check("reset phy_strb", 64'(phy_strb_o), 64'd0);
    check("reset phy_last", 64'(phy_last_o), 64'd0);
    check("reset err", 64'(err_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Wide aligned burst.
    load_wide();
    run_burst("wide", 0, 3, 1, 1'b0, -1, 0, -1, -1);
    check_wide("wide");

    // Narrow beats merged two per PHY word; junk outside each window.
    beat_data[0] = 64'h1111_2222_3333_AAAA;
    beat_data[1] = 64'h4444_5555_BBBB_6666;
    beat_data[2] = 64'h7777_CCCC_8888_9999;
    beat_data[3] = 64'hDDDD_EEEE_FFFF_1234;
    for (int i = 0; i < 4; i++) beat_strb[i] = 8'hFF;
    run_burst("narrow", 0, 1, 3, 1'b0, -1, 0, -1, -1);
    check("narrow lit count", 64'(got_q.size()), 64'd2);
    check_lit("narrow", 0, 32'hBBBBAAAA, 4'hF, 1'b0);
    check_lit("narrow", 1, 32'hDDDDCCCC, 4'hF, 1'b1);

    // Unaligned single beat in the upper bytes.
    load_unaligned();
    run_burst("unaligned", 6, 3, 0, 1'b0, -1, 0, -1, -1);
    check_unaligned("unaligned");

    // Backpressure on the second word for 3 cycles.
    load_wide();
    run_burst("stall", 0, 3, 1, 1'b0, 1, 3, -1, -1);
    check_wide("stall");

    // W last asserted on beat 0 of a two-beat burst.
    load_wide();
    run_burst("badlast", 0, 3, 1, 1'b0, -1, 0, 0, -1);
    check_wide("badlast");
    check("badlast err sticky", 64'(err_o), 64'(ErrExp));
    load_unaligned();
    run_burst("errclear", 6, 3, 0, 1'b0, -1, 0, -1, -1);
    check("errclear err", 64'(err_o), 64'd0);

    // Reset during the second word, then a fresh transaction.
    load_wide();
    run_burst("abort", 0, 3, 1, 1'b0, -1, 0, -1, 1);
    check("abort after reset phy_valid", 64'(phy_valid_o), 64'd0);
    load_unaligned();
    run_burst("post_abort", 6, 3, 0, 1'b0, -1, 0, -1, -1);
    check_unaligned("post_abort");

    // Randomized bursts: any size, offset, length, strobes and handshaking.
    for (int t = 0; t < 30; t++) begin
      int sz  = $urandom_range(0, 3);
      int st  = $urandom_range(0, 7);
      int len = $urandom_range(0, 7);
      for (int b = 0; b <= len; b++) begin
        beat_data[b] = {$urandom, $urandom};
        beat_strb[b] = 8'($urandom);
      end
      run_burst($sformatf("rnd%0d", t), st, sz, len, 1'b1,
                $urandom_range(0, 3), $urandom_range(0, 3), -1, -1);
      check($sformatf("rnd%0d err", t), 64'(err_o), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
